spi_request_arbiter: RTL and testbench

Shares the single `spi_controller` between several on-chip requesters, such as `control_unit` host commands, a DAC refresh sequencer and an ADC register poller. The arbiter grants requesters round-robin and issues one SPI transaction at a time on the controller's request/busy handshake. It returns ADC readback data, or a timeout error, to the granted requester. It sits in the `sys_clk` domain, between the requesters and `spi_controller`.

---
 rtl/spi_request_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_request_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter
//
// Shares one spi_controller between N on-chip requesters. Requesters are
// granted round-robin. One SPI transaction at a time goes out on the
// controller's strobe/busy handshake. The ADC readback data, or an error
// flag, goes back to the granted requester with a one-cycle ack.
//
// State table:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | no transaction; grant the next pending requester
//   S_ISSUE     | pulse the strobe for the latched op (none for reserved op)
//   S_WAIT_BUSY | wait for spi_busy to rise, bounded by BUSY_WAIT cycles
//   S_WAIT_DONE | wait for spi_busy to fall; capture ADC readback then
//   S_RESPOND   | pulse ack[grant] with ack_err / ack_rdata
//
// Ports:
//   sys_clk_i            system clock (only clock)
//   reset_i              synchronous active-high reset
//   req_i[N]             per-requester request, held until its ack
//   req_op_i[2N]         op of requester i at [2i+:2]
//                        00 DAC wr, 01 ADC wr, 10 ADC rd, 11 reserved
//   req_addr_i[16N]      address of requester i at [16i+:16]
//   req_wdata_i[16N]     write data of requester i at [16i+:16]
//   ack_o[N]             one-hot completion pulse
//   ack_err_o            with ack: reserved op or busy timeout
//   ack_rdata_o[8]       with ack: ADC read data, 0 for other ops
//   dac_request_write_o  DAC write strobe
//   dac_address_o[5]     DAC address
//   dac_data_o[12]       DAC data
//   adc_request_write_o  ADC write strobe
//   adc_request_read_o   ADC read strobe
//   adc_address_o[16]    ADC address
//   adc_data_o[8]        ADC write data (0 for reads)
//   adc_data_readback_i  ADC read data, valid in the cycle spi_busy falls
//   spi_busy_i           controller busy flag
//   grant_id_o[3]        current or last granted requester

module spi_request_arbiter #(
    parameter int N         = 4,
    parameter int BUSY_WAIT = 15
) (
    input  logic              sys_clk_i,
    input  logic              reset_i,
    input  logic [N-1:0]      req_i,
    input  logic [2*N-1:0]    req_op_i,
    input  logic [16*N-1:0]   req_addr_i,
    input  logic [16*N-1:0]   req_wdata_i,
    output logic [N-1:0]      ack_o,
    output logic              ack_err_o,
    output logic [7:0]        ack_rdata_o,
    output logic              dac_request_write_o,
    output logic [4:0]        dac_address_o,
    output logic [11:0]       dac_data_o,
    output logic              adc_request_write_o,
    output logic              adc_request_read_o,
    output logic [15:0]       adc_address_o,
    output logic [7:0]        adc_data_o,
    input  logic [7:0]        adc_data_readback_i,
    input  logic              spi_busy_i,
    output logic [2:0]        grant_id_o
);

    localparam logic [1:0] OP_DAC_WR = 2'b00;
    localparam logic [1:0] OP_ADC_WR = 2'b01;
    localparam logic [1:0] OP_ADC_RD = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [2:0]  last_q;
    logic [2:0]  grant_q;
    logic [1:0]  op_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [7:0]  rdata_q;
    logic [4:0]  dac_address_q;
    logic [11:0] dac_data_q;
    logic [15:0] adc_address_q;
    logic [7:0]  adc_data_q;

    // Round-robin pick: first pending requester at or after (last+1) mod N.
    logic [7:0]  req_pad;
    logic [2:0]  sel;
    logic [2:0]  idx;
    logic        found;
    logic        grant_now;
    logic [1:0]  sel_op;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    assign req_pad = 8'(req_i);

    always_comb begin
        sel   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = 3'((int'(last_q) + k) % N);
            if (!found && req_pad[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // A busy controller defers the grant so no strobe lands on a live transfer.
    assign grant_now = (state_q == S_IDLE) && (|req_i) && !spi_busy_i;

    assign sel_op    = req_op_i[2*int'(sel) +: 2];
    assign sel_addr  = req_addr_i[16*int'(sel) +: 16];
    assign sel_wdata = req_wdata_i[16*int'(sel) +: 16];

    // State register
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_now) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_q == OP_RSVD) begin
                    state_d = S_RESPOND;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (spi_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q <= 8'd1) begin
                    state_d = S_RESPOND;
                end
            end
            S_WAIT_DONE: begin
                if (!spi_busy_i) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction datapath: grant bookkeeping, payload, timeout counter, result.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            last_q        <= 3'(N - 1);
            grant_q       <= '0;
            op_q          <= OP_DAC_WR;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            dac_address_q <= '0;
            dac_data_q    <= '0;
            adc_address_q <= '0;
            adc_data_q    <= '0;
        end else begin
            if (grant_now) begin
                last_q  <= sel;
                grant_q <= sel;
                op_q    <= sel_op;
                err_q   <= 1'b0;
                rdata_q <= '0;
                // Payload is loaded on the grant edge so it is already valid
                // alongside the strobe, then held until the next grant.
                case (sel_op)
                    OP_DAC_WR: begin
                        dac_address_q <= sel_addr[4:0];
                        dac_data_q    <= sel_wdata[11:0];
                    end
                    OP_ADC_WR: begin
                        adc_address_q <= sel_addr;
                        adc_data_q    <= sel_wdata[7:0];
                    end
                    OP_ADC_RD: begin
                        adc_address_q <= sel_addr;
                        adc_data_q    <= '0;
                    end
                    default: begin
                    end
                endcase
            end

            case (state_q)
                S_ISSUE: begin
                    cnt_q <= 8'(BUSY_WAIT);
                    if (op_q == OP_RSVD) begin
                        err_q <= 1'b1;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!spi_busy_i) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q <= 8'd1) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!spi_busy_i) begin
                        rdata_q <= (op_q == OP_ADC_RD) ? adc_data_readback_i : 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        dac_request_write_o = 1'b0;
        adc_request_write_o = 1'b0;
        adc_request_read_o  = 1'b0;
        ack_o               = '0;
        ack_err_o           = 1'b0;
        ack_rdata_o         = '0;

        if (state_q == S_ISSUE) begin
            dac_request_write_o = (op_q == OP_DAC_WR);
            adc_request_write_o = (op_q == OP_ADC_WR);
            adc_request_read_o  = (op_q == OP_ADC_RD);
        end

        if (state_q == S_RESPOND) begin
            ack_o       = {{(N-1){1'b0}}, 1'b1} << grant_q;
            ack_err_o   = err_q;
            ack_rdata_o = rdata_q;
        end
    end

    assign dac_address_o = dac_address_q;
    assign dac_data_o    = dac_data_q;
    assign adc_address_o = adc_address_q;
    assign adc_data_o    = adc_data_q;
    assign grant_id_o    = grant_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
module tb_spi_request_arbiter;

    localparam int N = 4;
    localparam int BW = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_op;
    logic [16*N-1:0] req_addr;
    logic [16*N-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic            ack_err;
    logic [7:0]      ack_rdata;
    logic            dac_wr;
    logic [4:0]      dac_address;
    logic [11:0]     dac_data;
    logic            adc_wr;
    logic            adc_rd;
    logic [15:0]     adc_address;
    logic [7:0]      adc_data;
    logic [7:0]      readback;
    logic            busy;
    logic [2:0]      grant_id;

    int checks = 0;
    int errors = 0;
    int ack_cnt [N];

    spi_request_arbiter #(.N(N), .BUSY_WAIT(BW)) dut (
        .sys_clk_i           (clk),
        .reset_i             (reset),
        .req_i               (req),
        .req_op_i            (req_op),
        .req_addr_i          (req_addr),
        .req_wdata_i         (req_wdata),
        .ack_o               (ack),
        .ack_err_o           (ack_err),
        .ack_rdata_o         (ack_rdata),
        .dac_request_write_o (dac_wr),
        .dac_address_o       (dac_address),
        .dac_data_o          (dac_data),
        .adc_request_write_o (adc_wr),
        .adc_request_read_o  (adc_rd),
        .adc_address_o       (adc_address),
        .adc_data_o          (adc_data),
        .adc_data_readback_i (readback),
        .spi_busy_i          (busy),
        .grant_id_o          (grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] wdata);
        req_op[2*i +: 2]      = op;
        req_addr[16*i +: 16]  = addr;
        req_wdata[16*i +: 16] = wdata;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        readback  = '0;
        busy      = 1'b0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;

        // Reset state
        tick(); tick(); tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_ack_err", 32'(ack_err), 32'h0);
        check("rst_ack_rdata", 32'(ack_rdata), 32'h0);
        check("rst_strobes", 32'({dac_wr, adc_wr, adc_rd}), 32'h0);
        check("rst_payload", 32'({dac_address, dac_data}), 32'h0);
        check("rst_adc_payload", 32'({adc_address, adc_data}), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        reset = 1'b0;

        // Requester 2 ADC write 0x0008 <- 0x00A5
        set_req(2, 2'b01, 16'h0008, 16'h00A5);
        req = 4'b0100;
        tick();
        check("t1_adc_wr_strobe", 32'(adc_wr), 32'h1);
        check("t1_other_strobes", 32'({dac_wr, adc_rd}), 32'h0);
        check("t1_adc_address", 32'(adc_address), 32'h0008);
        check("t1_adc_data", 32'(adc_data), 32'hA5);
        check("t1_grant_id", 32'(grant_id), 32'h2);
        busy = 1'b1;
        tick();
        check("t1_strobe_one_cycle", 32'(adc_wr), 32'h0);
        tick();
        tick();
        check("t1_no_ack_while_busy", 32'(ack), 32'h0);
        busy = 1'b0;
        tick();
        check("t1_ack", 32'(ack), 32'b0100);
        check("t1_ack_err", 32'(ack_err), 32'h0);
        check("t1_ack_rdata", 32'(ack_rdata), 32'h0);
        req = '0;
        tick();
        check("t1_ack_one_cycle", 32'(ack), 32'h0);
        check("t1_payload_held", 32'(adc_address), 32'h0008);

        // Reset, then all four requesters hold DAC writes: order 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            set_req(i, 2'b00, 16'h0010 + 16'(i), 16'hA000 | 16'(i * 16'h111));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(k % N));
            check($sformatf("rr%0d_dac_strobe", k), 32'({dac_wr, adc_wr, adc_rd}), 32'b100);
            check($sformatf("rr%0d_dac_address", k), 32'(dac_address), 32'(5'h10 + 5'(k % N)));
            check($sformatf("rr%0d_dac_data", k), 32'(dac_data), 32'((k % N) * 12'h111));
            busy = 1'b1;
            tick();
            tick();
            busy = 1'b0;
            tick();
            check($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << (k % N)));
            for (int i = 0; i < N; i++) ack_cnt[i] += int'(ack[i]);
            if (k == 3) begin
                for (int i = 0; i < N; i++)
                    check($sformatf("rr_round_acks_req%0d", i), 32'(ack_cnt[i]), 32'h1);
            end
            if (k == 4) req = '0;
            tick();
        end
        check("rr_req0_second_ack", 32'(ack_cnt[0]), 32'h2);

        // Requester 1 ADC read 0x0001, readback 0x3C
        set_req(1, 2'b10, 16'h0001, 16'hBEEF);
        req = 4'b0010;
        tick();
        check("rd_strobe", 32'({dac_wr, adc_wr, adc_rd}), 32'b001);
        check("rd_adc_address", 32'(adc_address), 32'h0001);
        check("rd_adc_data", 32'(adc_data), 32'h0);
        check("rd_grant", 32'(grant_id), 32'h1);
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        readback = 8'h3C;
        tick();
        readback = 8'h77;
        check("rd_ack", 32'(ack), 32'b0010);
        check("rd_ack_rdata", 32'(ack_rdata), 32'h3C);
        check("rd_ack_err", 32'(ack_err), 32'h0);
        req = '0;
        tick();

        // Requester 3 DAC write 0x0013 <- 0xF800, busy never rises
        set_req(3, 2'b00, 16'h0013, 16'hF800);
        req = 4'b1000;
        tick();
        check("to_dac_strobe", 32'(dac_wr), 32'h1);
        check("to_dac_address", 32'(dac_address), 32'h13);
        check("to_dac_data", 32'(dac_data), 32'h800);
        repeat (15) tick();
        check("to_no_ack_t16", 32'(ack), 32'h0);
        tick();
        check("to_ack_t17", 32'(ack), 32'b1000);
        check("to_ack_err", 32'(ack_err), 32'h1);
        check("to_ack_rdata", 32'(ack_rdata), 32'h0);
        req = '0;
        tick();

        // Reserved op from requester 1
        set_req(1, 2'b11, 16'h1234, 16'h5678);
        req = 4'b0010;
        tick();
        check("rsv_no_strobe", 32'({dac_wr, adc_wr, adc_rd}), 32'h0);
        tick();
        check("rsv_ack_t2", 32'(ack), 32'b0010);
        check("rsv_ack_err", 32'(ack_err), 32'h1);
        req = '0;
        tick();

        // New transaction from requester 2, reset during WAIT_DONE
        set_req(2, 2'b01, 16'h0042, 16'h0011);
        req = 4'b0100;
        tick();
        check("rst_tx_strobe", 32'(adc_wr), 32'h1);
        busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        busy  = 1'b0;
        tick();
        check("mid_rst_ack", 32'(ack), 32'h0);
        check("mid_rst_ack_err_rdata", 32'({ack_err, ack_rdata}), 32'h0);
        check("mid_rst_strobes", 32'({dac_wr, adc_wr, adc_rd}), 32'h0);
        check("mid_rst_payload", 32'({adc_address, adc_data, dac_address, dac_data}), 32'h0);
        check("mid_rst_grant_id", 32'(grant_id), 32'h0);
        reset = 1'b0;

        // Grant deferred while busy, then requester 0 wins
        set_req(0, 2'b01, 16'h0005, 16'h005A);
        req  = 4'b0101;
        busy = 1'b1;
        tick();
        check("defer_no_strobe", 32'({dac_wr, adc_wr, adc_rd}), 32'h0);
        check("defer_no_ack", 32'(ack), 32'h0);
        busy = 1'b0;
        tick();
        check("post_rst_strobe", 32'(adc_wr), 32'h1);
        check("post_rst_grant", 32'(grant_id), 32'h0);
        check("post_rst_adc_address", 32'(adc_address), 32'h0005);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
